// File: rtl/pwm_generator_mc_if.sv
// pwm_generator_mc_if: config write bus (wr_en/wr_addr/wr_data) plus PWM outputs (pwm_out/period_end)
interface pwm_generator_mc_if #(
  parameter int WIDTH = 12,
  parameter int CHANNELS = 4,
  parameter int ADDR_W = 4
);
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [CHANNELS-1:0] pwm_out;
  logic period_end;
  modport master (output wr_en, wr_addr, wr_data, input pwm_out, period_end);
  modport slave (input wr_en, wr_addr, wr_data, output pwm_out, period_end);
endinterface

// File: rtl/pwm_generator_mc.sv
// pwm_generator_mc: double-buffered multi-channel edge/centre PWM; ports clk, rst, bus (writes in, pwm_out/period_end out)
module pwm_generator_mc #(
  parameter int WIDTH = 12,
  parameter int CHANNELS = 4,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic rst,
  pwm_generator_mc_if.slave bus
);
  localparam int CW = 2*CHANNELS+1;
  logic [WIDTH-1:0] s_period, a_period, n_period, cnt;
  logic [CW-1:0] s_ctrl, a_ctrl, n_ctrl;
  logic [WIDTH-1:0] s_duty [CHANNELS];
  logic [WIDTH-1:0] a_duty [CHANNELS];
  logic [WIDTH-1:0] n_duty [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic dir, commit;
  always_comb begin
    n_period = (bus.wr_en && bus.wr_addr == ADDR_W'(0)) ? bus.wr_data : s_period;
    n_ctrl = (bus.wr_en && bus.wr_addr == ADDR_W'(1)) ? bus.wr_data[CW-1:0] : s_ctrl;
    for (int i = 0; i < CHANNELS; i++) begin
      n_duty[i] = (bus.wr_en && bus.wr_addr == ADDR_W'(2+i)) ? bus.wr_data : s_duty[i];
      raw[i] = a_ctrl[1+i] && (cnt < a_duty[i]);
    end
    commit = (a_period == '0) || (a_ctrl[0] ? (dir && cnt == WIDTH'(1)) : (cnt == a_period - WIDTH'(1)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_period <= '0;
      a_period <= '0;
      s_ctrl <= '0;
      a_ctrl <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        s_duty[i] <= '0;
        a_duty[i] <= '0;
      end
      cnt <= '0;
      dir <= 1'b0;
      bus.pwm_out <= '0;
      bus.period_end <= 1'b0;
    end else begin
      s_period <= n_period;
      s_ctrl <= n_ctrl;
      s_duty <= n_duty;
      if (commit) begin
        a_period <= n_period;
        a_ctrl <= n_ctrl;
        a_duty <= n_duty;
        cnt <= '0;
        dir <= 1'b0;
      end else if (a_ctrl[0] && dir) begin
        cnt <= cnt - WIDTH'(1);
      end else begin
        cnt <= cnt + WIDTH'(1);
        dir <= a_ctrl[0] && (cnt + WIDTH'(1) == a_period);
      end
      bus.pwm_out <= raw ^ a_ctrl[CW-1:CHANNELS+1];
      bus.period_end <= commit;
    end
  end
endmodule

// File: tb/tb_pwm_generator_mc.sv
// tb_pwm_generator_mc: table vectors, corner sequences and random writes checked against a phase-index model
module tb_pwm_generator_mc;
  localparam int W = 12;
  localparam int CH = 4;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pwm_generator_mc_if #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) bus ();
  pwm_generator_mc #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int applied = 0;
  int miscompares = 0;
  logic [W-1:0] sp, ap;
  logic [W-1:0] sd [CH];
  logic [W-1:0] ad [CH];
  logic [2*CH:0] sc, ac;
  int t;
  logic [CH-1:0] e_pwm;
  logic e_pe;
  int hc [CH];
  int pec;
  typedef struct {
    logic r;
    logic we;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    logic [CH-1:0] pwm;
    logic pe;
  } vec_t;
  vec_t tbl [$];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input logic r, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    int p, len, c;
    if (r) begin
      sp = '0; ap = '0; sc = '0; ac = '0;
      for (int i = 0; i < CH; i++) begin sd[i] = '0; ad[i] = '0; end
      t = 0; e_pwm = '0; e_pe = 1'b0;
      return;
    end
    p = int'(ap);
    len = (p == 0) ? 1 : (ac[0] ? 2*p : p);
    c = (p == 0) ? 0 : ((!ac[0] || t <= p) ? t : 2*p - t);
    for (int i = 0; i < CH; i++) e_pwm[i] = (ac[1+i] && c < int'(ad[i])) ^ ac[CH+1+i];
    e_pe = (t == len - 1);
    if (we) begin
      if (a == 0) sp = d;
      else if (a == 1) sc = d[2*CH:0];
      else if (a >= 2 && a < 2 + CH) sd[a-2] = d;
    end
    if (e_pe) begin
      ap = sp; ac = sc;
      for (int i = 0; i < CH; i++) ad[i] = sd[i];
      t = 0;
    end else t++;
  endtask
  task automatic cyc(input logic r, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    rst = r; bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk);
    model_step(r, we, a, d);
    #1;
    check("pwm_out", bus.pwm_out, e_pwm);
    check("period_end", bus.period_end, e_pe);
    for (int i = 0; i < CH; i++) hc[i] += bus.pwm_out[i];
    pec += bus.period_end;
    bus.wr_en = 1'b0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0);
  endtask
  task automatic clr();
    for (int i = 0; i < CH; i++) hc[i] = 0;
    pec = 0;
  endtask
  task automatic wait_pe();
    for (int k = 0; k < 100; k++) begin
      idle(1);
      if (bus.period_end === 1'b1) return;
    end
    check("wait_pe_timeout", 0, 1);
  endtask
  initial begin
    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    tbl.push_back('{1'b1, 1'b1, 4'd0, 12'd3, 4'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'd1, 12'h1E0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 12'd0, 4'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 4'd0, 12'd10, 4'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 4'd2, 12'd3, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd1, 12'd2, 4'h0, 1'b0});
    for (int k = 0; k < 7; k++) tbl.push_back('{1'b0, 1'b0, 4'd0, 12'd0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 12'd0, 4'h0, 1'b1});
    for (int k = 0; k < 3; k++) tbl.push_back('{1'b0, 1'b0, 4'd0, 12'd0, 4'h1, 1'b0});
    for (int k = 0; k < 6; k++) tbl.push_back('{1'b0, 1'b0, 4'd0, 12'd0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 12'd0, 4'h0, 1'b1});
    clr();
    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].we, tbl[k].a, tbl[k].d);
      check($sformatf("tbl%0d_pwm", k), bus.pwm_out, tbl[k].pwm);
      check($sformatf("tbl%0d_pe", k), bus.period_end, tbl[k].pe);
    end
    wr(4'd3, 12'd0);
    wr(4'd4, 12'd10);
    wr(4'd1, 12'h10E);
    wait_pe();
    clr(); idle(10);
    check("duty3_ch0", hc[0], 3);
    check("duty0_ch1", hc[1], 0);
    check("dutyP_ch2", hc[2], 10);
    check("pol_dis_ch3", hc[3], 10);
    check("edge_pe_count", pec, 1);
    wr(4'd4, 12'd4095);
    wait_pe();
    clr(); idle(10);
    check("duty4095_ch2", hc[2], 10);
    clr(); idle(4); wr(4'd2, 12'd7); idle(5);
    check("dbuf_old_duty", hc[0], 3);
    check("dbuf_commit_pe", bus.period_end, 1);
    clr(); idle(9); wr(4'd2, 12'd5);
    check("dbuf_new_duty", hc[0], 7);
    check("commit_cycle_pe", bus.period_end, 1);
    clr(); idle(10);
    check("commit_cycle_write", hc[0], 5);
    wr(4'd0, 12'd4);
    wr(4'd2, 12'd2);
    wr(4'd1, 12'd3);
    wait_pe();
    clr(); idle(7);
    check("centre_no_early_pe", pec, 0);
    idle(1);
    check("centre_pe_last", bus.period_end, 1);
    check("centre_high", hc[0], 3);
    wr(4'd1, 12'h0A0);
    wr(4'd0, 12'd0);
    wait_pe();
    clr(); idle(5);
    check("p0_pe_every", pec, 5);
    check("p0_pol_ch0", hc[0], 5);
    check("p0_pol_ch1", hc[1], 0);
    check("p0_out", bus.pwm_out, 4'b0101);
    wr(4'd0, 12'd5);
    idle(1);
    check("p5_resume_pe", bus.period_end, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [AW-1:0] a;
      logic [W-1:0] d;
      a = AW'($urandom_range(0, 7));
      d = (a == 0) ? W'($urandom_range(0, 12)) : (a == 1) ? W'($urandom) :
          ($urandom_range(0, 9) == 0) ? W'(4095) : W'($urandom_range(0, 14));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, a, d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
